mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers each execute-stage result and performs the data-memory access for loads and stores through a req/ack handshake.
- Drives the register-file write port and reports the branch redirect.
- Stalls the upstream stage via ready_out while a memory access is outstanding; a timeout turns a hung access into an error pulse.

Parameters:
- DATA_W, 32, width of data, addresses, PC and memory bus.
- RF_ADDR_W, 4, register-file address width.
- TIMEOUT_CYCLES, 255, memory-wait cycles without mem_ack before the access is aborted (range 1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  execute outputs below are valid this cycle.
- ready_out  out  1  stage can accept; transfer occurs when valid_in && ready_out.
- exe_out  in  DATA_W  ALU result or condition bit; memory address for load/store.
- z_flag  in  1  condition result.
- is_branch  in  1  instruction is a branch.
- pc_target  in  DATA_W  branch target (pc+imm).
- needs_wb  in  1  instruction writes the register file.
- is_load  in  1  load instruction.
- is_store  in  1  store instruction.
- store_data  in  DATA_W  store write data.
- wb_addr  in  RF_ADDR_W  destination register.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write (store), 0 = read (load).
- mem_addr  out  DATA_W  access address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle access completion.
- rf_we  out  1  register-file write strobe, single-cycle pulse.
- rf_waddr  out  RF_ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- br_taken  out  1  one-cycle pulse: branch taken.
- br_target  out  DATA_W  redirect PC, valid while br_taken=1.
- mem_err  out  1  one-cycle pulse: access aborted on timeout.
- retired_cnt  out  32  completed-instruction counter.

Behaviour:
- Reset (async, rst_n=0): state IDLE and every output 0, including ready_out. The timeout counter and all captured registers are cleared. A reset during MEM drops mem_req immediately; no RF write and no mem_err occur.
- States:
  - IDLE: ready_out=1.
  - MEM: ready_out=0; valid_in and the execute-stage inputs are ignored; upstream must hold.
- Accept in IDLE when valid_in=1. All inputs are captured at that edge. Write-back and branch outputs are registered, so responses appear exactly one cycle after acceptance.
- Non-memory accept at edge N:
  - During cycle N+1: rf_we=needs_wb, rf_waddr=wb_addr, rf_wdata=exe_out.
  - br_taken=is_branch&z_flag, br_target=pc_target.
  - State stays IDLE, giving a throughput of one instruction per cycle.
- Memory accept at edge N (is_load or is_store):
  - Branch pulse is issued at N+1 exactly as for non-memory instructions.
  - State goes to MEM. From N+1: mem_req=1, mem_addr=exe_out, mem_we=is_store, mem_wdata=store_data. All stay stable until the access completes.
  - If is_load and is_store are both set, the store wins: mem_we=1 and no RF write.
- mem_ack is sampled only while mem_req=1; otherwise it is ignored. An ack in the first MEM cycle is legal.
- Ack at edge M:
  - mem_req drops and state returns to IDLE, so ready_out=1 in cycle M+1.
  - For a load with needs_wb: rf_we pulses in cycle M+1 with the mem_rdata sampled at M.
  - For a store: no RF write.
- Timeout:
  - The counter clears on entry to MEM and increments on each MEM edge without ack.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, mem_err pulses for one cycle, there is no RF write, state returns to IDLE, and the instruction does not retire.
  - An ack on the same edge as the timeout wins: a normal completion with no error.
- retired_cnt increments by 1 on each completion: every non-memory accept, and every acked load or store. It is visible one cycle after the completion edge and wraps from 0xFFFFFFFF to 0.
- rf_we for wb_addr=0 is forwarded unchanged; register-0 policy belongs to the register file.
- When no pulse is active, rf_we, br_taken and mem_err are 0. Data outputs keep their last value.

Test Plan:
- Reset mid-access: reset released, then ADD accepted with exe_out=0x15, wb_addr=3, needs_wb=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x15, retired_cnt=1, ready_out stays 1.
- Load with exe_out=0x100, mem_ack after 3 wait cycles carrying rdata=0xDEADBEEF, wb_addr=5 -> mem_req high for 4 cycles with mem_addr=0x100 and mem_we=0; ready_out=0 throughout; rf_we pulse with 0xDEADBEEF to r5 one cycle after ack.
- Store with exe_out=0x40, store_data=0x1234, ack in the first cycle -> mem_we=1, mem_wdata=0x1234, no rf_we, ready_out=1 the cycle after ack.
- Branch with is_branch=1, z_flag=1, pc_target=0x80 -> br_taken pulse with br_target=0x80. Same with z_flag=0 -> no pulse.
- Load with TIMEOUT_CYCLES=4 and no ack -> mem_req drops after 4 cycles, single mem_err pulse, no rf_we, retired_cnt unchanged. Reset asserted during the wait of a second load -> mem_req=0 immediately.
- Back-to-back ALU ops for 10 cycles with valid_in=1 -> 10 consecutive rf_we pulses, retired_cnt=10.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and write-back pipeline stage
module mem_wb_stage #(
   parameter int DATA_W         = 32,
   parameter int RF_ADDR_W      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   output logic                 ready_out,
   input  logic [DATA_W-1:0]    exe_out,
   input  logic                 z_flag,
   input  logic                 is_branch,
   input  logic [DATA_W-1:0]    pc_target,
   input  logic                 needs_wb,
   input  logic                 is_load,
   input  logic                 is_store,
   input  logic [DATA_W-1:0]    store_data,
   input  logic [RF_ADDR_W-1:0] wb_addr,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [DATA_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_ack,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic                 br_taken,
   output logic [DATA_W-1:0]    br_target,
   output logic                 mem_err,
   output logic [31:0]          retired_cnt
);

   typedef enum logic {IDLE, MEM} state_t;

   // Nine bits so that count+1 cannot wrap before matching a limit of 255.
   localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

   state_t                 state, state_nxt;
   logic                   accept, is_mem, ack_hit, tmo_hit;
   logic [7:0]             tmo_cnt;
   logic                   ld_wb;
   logic [RF_ADDR_W-1:0]   ld_waddr;

   assign is_mem  = is_load | is_store;
   assign accept  = (state == IDLE) && ready_out && valid_in;
   assign ack_hit = (state == MEM) && mem_req && mem_ack;
   // An ack on the timeout edge takes priority, so the abort needs !mem_ack.
   assign tmo_hit = (state == MEM) && !mem_ack && (({1'b0, tmo_cnt} + 9'd1) == TMO_LIMIT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: a memory instruction parks the stage in MEM until ack or timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && is_mem)     state_nxt = MEM;
         MEM:  if (ack_hit || tmo_hit)   state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   // Registered outputs: pulses default low, data outputs hold their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_out   <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         br_taken    <= 1'b0;
         br_target   <= '0;
         mem_err     <= 1'b0;
         retired_cnt <= '0;
         tmo_cnt     <= '0;
         ld_wb       <= 1'b0;
         ld_waddr    <= '0;
      end else begin
         rf_we     <= 1'b0;
         br_taken  <= 1'b0;
         mem_err   <= 1'b0;
         ready_out <= (state_nxt == IDLE);
         if (accept) begin
            br_taken  <= is_branch & z_flag;
            br_target <= pc_target;
            if (is_mem) begin
               mem_req   <= 1'b1;
               mem_we    <= is_store;
               mem_addr  <= exe_out;
               mem_wdata <= store_data;
               tmo_cnt   <= '0;
               // A combined load+store behaves as a store: no write-back.
               ld_wb     <= is_load & ~is_store & needs_wb;
               ld_waddr  <= wb_addr;
            end else begin
               rf_we       <= needs_wb;
               rf_waddr    <= wb_addr;
               rf_wdata    <= exe_out;
               retired_cnt <= retired_cnt + 32'd1;
            end
         end else if (ack_hit) begin
            mem_req     <= 1'b0;
            rf_we       <= ld_wb;
            retired_cnt <= retired_cnt + 32'd1;
            if (ld_wb) begin
               rf_waddr <= ld_waddr;
               rf_wdata <= mem_rdata;
            end
         end else if (tmo_hit) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
         end else if (state == MEM) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_in = 1'b0;
   logic          ready_out;
   logic [DW-1:0] exe_out = '0;
   logic          z_flag = 1'b0;
   logic          is_branch = 1'b0;
   logic [DW-1:0] pc_target = '0;
   logic          needs_wb = 1'b0;
   logic          is_load = 1'b0;
   logic          is_store = 1'b0;
   logic [DW-1:0] store_data = '0;
   logic [AW-1:0] wb_addr = '0;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          br_taken;
   logic [DW-1:0] br_target;
   logic          mem_err;
   logic [31:0]   retired_cnt;

   mem_wb_stage #(.DATA_W(DW), .RF_ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
      .exe_out(exe_out), .z_flag(z_flag), .is_branch(is_branch), .pc_target(pc_target),
      .needs_wb(needs_wb), .is_load(is_load), .is_store(is_store), .store_data(store_data),
      .wb_addr(wb_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .br_taken(br_taken), .br_target(br_target),
      .mem_err(mem_err), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        ready, rf_we, br, req, we, err;
      logic [31:0] waddr, wdata, brt, addr, mwdata, ret;
   } exp_t;

   exp_t        exp_a [0:8191];
   bit          exp_v [0:8191];
   exp_t        cx;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] m_ret = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      n_chk++;
      if (act === ex) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, ex);
   endtask

   // Expected outputs of a cycle in which nothing completes.
   function automatic exp_t idle_exp();
      exp_t x;
      x.ready = 1'b1; x.rf_we = 1'b0; x.br = 1'b0; x.req = 1'b0; x.we = 1'b0; x.err = 1'b0;
      x.waddr = '0; x.wdata = '0; x.brt = '0; x.addr = '0; x.mwdata = '0; x.ret = m_ret;
      return x;
   endfunction

   task automatic set_exp(input exp_t x);
      exp_a[cyc+1] = x;
      exp_v[cyc+1] = 1'b1;
   endtask

   task automatic junk();
      exe_out = $urandom; z_flag = 1'($urandom); is_branch = 1'($urandom);
      pc_target = $urandom; needs_wb = 1'($urandom); is_load = 1'($urandom);
      is_store = 1'($urandom); store_data = $urandom; wb_addr = 4'($urandom);
      mem_rdata = $urandom;
   endtask

   // Compare the DUT against the expected timeline every cycle it is defined.
   always @(negedge clk) begin
      if (cyc < 8192 && exp_v[cyc]) begin
         cx = exp_a[cyc];
         chk("ready_out", 32'(ready_out), 32'(cx.ready));
         chk("rf_we", 32'(rf_we), 32'(cx.rf_we));
         chk("br_taken", 32'(br_taken), 32'(cx.br));
         chk("mem_req", 32'(mem_req), 32'(cx.req));
         chk("mem_err", 32'(mem_err), 32'(cx.err));
         chk("retired_cnt", retired_cnt, cx.ret);
         if (cx.rf_we) begin
            chk("rf_waddr", 32'(rf_waddr), cx.waddr);
            chk("rf_wdata", rf_wdata, cx.wdata);
         end
         if (cx.br) chk("br_target", br_target, cx.brt);
         if (cx.req) begin
            chk("mem_we", 32'(mem_we), 32'(cx.we));
            chk("mem_addr", mem_addr, cx.addr);
            chk("mem_wdata", mem_wdata, cx.mwdata);
         end
      end
   end

   task automatic do_reset();
      exp_t x;
      rst_n = 1'b0; valid_in = 1'b0; mem_ack = 1'b0;
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_ready", 32'(ready_out), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      chk("rst_retired", retired_cnt, 32'd0);
      m_ret = '0;
      x = idle_exp();
      x.ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_exp(x);
         @(negedge clk); #1;
      end
      rst_n = 1'b1;
      set_exp(idle_exp());
   endtask

   task automatic idle_cycle();
      @(negedge clk); #1;
      junk();
      valid_in = 1'b0;
      mem_ack = 1'($urandom);
      set_exp(idle_exp());
   endtask

   // One instruction; for memory ops ack_k is the MEM cycle index that acks
   // (outside 0..TMO-1 means never) and rst_k the MEM cycle where reset hits.
   task automatic issue(input logic br, input logic z, input logic nwb, input logic ld,
                        input logic st, input logic [31:0] exe, input logic [31:0] pct,
                        input logic [31:0] sd, input logic [3:0] wa, input int ack_k,
                        input logic [31:0] rd, input int rst_k);
      exp_t x;
      bit   mem;
      @(negedge clk); #1;
      junk();
      valid_in = 1'b1; exe_out = exe; z_flag = z; is_branch = br; pc_target = pct;
      needs_wb = nwb; is_load = ld; is_store = st; store_data = sd; wb_addr = wa;
      mem_ack = 1'($urandom);
      mem = ld | st;
      x = idle_exp();
      x.ready = !mem; x.br = br & z; x.brt = pct;
      if (mem) begin
         x.req = 1'b1; x.we = st; x.addr = exe; x.mwdata = sd;
      end else begin
         x.rf_we = nwb; x.waddr = 32'(wa); x.wdata = exe;
         m_ret = m_ret + 1; x.ret = m_ret;
      end
      set_exp(x);
      if (mem) begin
         for (int k = 0; k < TMO; k++) begin
            @(negedge clk); #1;
            if (k == rst_k) begin
               do_reset();
               return;
            end
            junk();
            valid_in = 1'($urandom);
            mem_ack = (k == ack_k);
            if (k == ack_k) mem_rdata = rd;
            x = idle_exp();
            if (k == ack_k) begin
               x.rf_we = ld & ~st & nwb; x.waddr = 32'(wa); x.wdata = rd;
               m_ret = m_ret + 1; x.ret = m_ret;
            end else if (k + 1 == TMO) begin
               x.err = 1'b1;
            end else begin
               x.ready = 1'b0; x.req = 1'b1; x.we = st; x.addr = exe; x.mwdata = sd;
            end
            set_exp(x);
            if (k == ack_k) break;
         end
      end
   endtask

   task automatic after_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      @(negedge clk); #1;
      do_reset();

      // Load interrupted by reset, then a plain ADD.
      issue(0, 0, 1, 1, 0, 32'h200, 0, 0, 4'd7, -1, 0, 2);
      issue(0, 0, 1, 0, 0, 32'h15, 0, 0, 4'd3, -1, 0, -1);
      after_edge();
      chk("add_rf_we", 32'(rf_we), 32'd1);
      chk("add_rf_waddr", 32'(rf_waddr), 32'd3);
      chk("add_rf_wdata", rf_wdata, 32'h15);
      chk("add_retired", retired_cnt, 32'd1);
      chk("add_ready", 32'(ready_out), 32'd1);

      // Load with three wait cycles.
      issue(0, 0, 1, 1, 0, 32'h100, 0, 0, 4'd5, 3, 32'hDEADBEEF, -1);
      after_edge();
      chk("ld_rf_we", 32'(rf_we), 32'd1);
      chk("ld_rf_waddr", 32'(rf_waddr), 32'd5);
      chk("ld_rf_wdata", rf_wdata, 32'hDEADBEEF);
      chk("ld_ready", 32'(ready_out), 32'd1);
      chk("ld_retired", retired_cnt, 32'd2);

      // Store acked in its first MEM cycle.
      issue(0, 0, 0, 0, 1, 32'h40, 0, 32'h1234, 4'd0, 0, 0, -1);
      after_edge();
      chk("st_rf_we", 32'(rf_we), 32'd0);
      chk("st_ready", 32'(ready_out), 32'd1);
      chk("st_retired", retired_cnt, 32'd3);

      // Branch taken, then not taken.
      issue(1, 1, 0, 0, 0, 0, 32'h80, 0, 4'd0, -1, 0, -1);
      after_edge();
      chk("br1_taken", 32'(br_taken), 32'd1);
      chk("br1_target", br_target, 32'h80);
      issue(1, 0, 0, 0, 0, 0, 32'h80, 0, 4'd0, -1, 0, -1);
      after_edge();
      chk("br0_taken", 32'(br_taken), 32'd0);
      chk("br0_retired", retired_cnt, 32'd5);

      // Load that never acks.
      issue(0, 0, 1, 1, 0, 32'h300, 0, 0, 4'd6, -1, 0, -1);
      after_edge();
      chk("tmo_err", 32'(mem_err), 32'd1);
      chk("tmo_req", 32'(mem_req), 32'd0);
      chk("tmo_rf_we", 32'(rf_we), 32'd0);
      chk("tmo_retired", retired_cnt, 32'd5);
      idle_cycle();
      after_edge();
      chk("tmo_err_single", 32'(mem_err), 32'd0);

      // Second load cut by reset during its wait.
      issue(0, 0, 1, 1, 0, 32'h304, 0, 0, 4'd2, -1, 0, 1);

      // Ten back-to-back ALU ops.
      for (int i = 0; i < 10; i++)
         issue(0, 0, 1, 0, 0, 32'(i * 3 + 1), 0, 0, 4'(i), -1, 0, -1);
      after_edge();
      chk("b2b_retired", retired_cnt, 32'd10);

      // Ack coinciding with the timeout edge completes normally.
      issue(0, 0, 1, 1, 0, 32'h500, 0, 0, 4'd9, TMO - 1, 32'hCAFEF00D, -1);
      after_edge();
      chk("edge_ack_err", 32'(mem_err), 32'd0);
      chk("edge_ack_wdata", rf_wdata, 32'hCAFEF00D);
      chk("edge_ack_retired", retired_cnt, 32'd11);

      // Randomized mix.
      for (int n = 0; n < 300; n++) begin
         int t;
         int ak;
         t  = $urandom_range(0, 5);
         ak = $urandom_range(0, TMO);
         case (t)
            0, 1: issue(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, $urandom, $urandom,
                        $urandom, 4'($urandom), -1, 0, -1);
            2:    issue(1'($urandom), 1'($urandom), 1'($urandom), 1, 0, $urandom, $urandom,
                        $urandom, 4'($urandom), ak, $urandom, -1);
            3:    issue(1'($urandom), 1'($urandom), 1'($urandom), 0, 1, $urandom, $urandom,
                        $urandom, 4'($urandom), ak, $urandom, -1);
            4:    issue(1'($urandom), 1'($urandom), 1, 1, 1, $urandom, $urandom,
                        $urandom, 4'($urandom), ak, $urandom, -1);
            default: idle_cycle();
         endcase
      end
      idle_cycle();
      idle_cycle();
      @(negedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
